// File: rtl/vga_box_drawer.sv
// Pixel sequencer for the VGA adapter: plots a clipped BOX_W x BOX_H filled box
// at a latched origin, or sweeps the whole screen to black, one pixel per clock.
//
//  state   | meaning
//  --------+--------------------------------------------------------------
//  S_IDLE  | waiting; load latches origin/colour, clear/draw start an op
//  S_DRAW  | rastering the box, x fastest; off-screen pixels have plot=0
//  S_CLEAR | rastering the full screen with colour 0
//  S_DONE  | single-cycle completion pulse, then back to S_IDLE
module vga_box_drawer #(
    parameter int BOX_W = 4,
    parameter int BOX_H = 4,
    parameter int SCR_W = 160,
    parameter int SCR_H = 120
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic [7:0] x_in,
    input  logic [6:0] y_in,
    input  logic [2:0] color_in,
    input  logic       load,
    input  logic       draw,
    input  logic       clear,
    output logic [7:0] VGA_X,
    output logic [6:0] VGA_Y,
    output logic [2:0] VGA_COLOR,
    output logic       plot,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRAW  = 2'd1,
        S_CLEAR = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [7:0] BOX_X_LAST = 8'(BOX_W - 1);
    localparam logic [6:0] BOX_Y_LAST = 7'(BOX_H - 1);
    localparam logic [7:0] SCR_X_LAST = 8'(SCR_W - 1);
    localparam logic [6:0] SCR_Y_LAST = 7'(SCR_H - 1);
    localparam logic [8:0] SCR_W_LIM  = 9'(SCR_W);
    localparam logic [7:0] SCR_H_LIM  = 8'(SCR_H);

    state_t     state_q, state_d;
    logic [7:0] x_q, x_d;
    logic [6:0] y_q, y_d;
    logic [2:0] col_q, col_d;
    logic [7:0] cx_q, cx_d;
    logic [6:0] cy_q, cy_d;

    // Widened sums so a box hanging past the edge clips instead of wrapping to 0.
    logic [8:0] px;
    logic [7:0] py;

    assign px = {1'b0, x_q} + {1'b0, cx_q};
    assign py = {1'b0, y_q} + {1'b0, cy_q};

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            col_q   <= '0;
            cx_q    <= '0;
            cy_q    <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            col_q   <= col_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        col_d   = col_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        unique case (state_q)
            S_IDLE: begin
                if (load) begin
                    x_d   = x_in;
                    y_d   = y_in;
                    col_d = color_in;
                end
                if (clear || draw) begin
                    cx_d    = '0;
                    cy_d    = '0;
                    state_d = clear ? S_CLEAR : S_DRAW;
                end
            end
            S_DRAW: begin
                if (cx_q == BOX_X_LAST) begin
                    cx_d = '0;
                    if (cy_q == BOX_Y_LAST) begin
                        cy_d    = '0;
                        state_d = S_DONE;
                    end else begin
                        cy_d = cy_q + 7'd1;
                    end
                end else begin
                    cx_d = cx_q + 8'd1;
                end
            end
            S_CLEAR: begin
                if (cx_q == SCR_X_LAST) begin
                    cx_d = '0;
                    if (cy_q == SCR_Y_LAST) begin
                        cy_d    = '0;
                        state_d = S_DONE;
                    end else begin
                        cy_d = cy_q + 7'd1;
                    end
                end else begin
                    cx_d = cx_q + 8'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs depend only on registers, so reset clears them without a clock.
    always_comb begin
        VGA_X     = '0;
        VGA_Y     = '0;
        VGA_COLOR = '0;
        plot      = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state_q)
            S_DRAW: begin
                VGA_X     = px[7:0];
                VGA_Y     = py[6:0];
                VGA_COLOR = col_q;
                plot      = (px < SCR_W_LIM) && (py < SCR_H_LIM);
                busy      = 1'b1;
            end
            S_CLEAR: begin
                VGA_X = cx_q;
                VGA_Y = cy_q;
                plot  = 1'b1;
                busy  = 1'b1;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_vga_box_drawer.sv
// Scoreboard bench for vga_box_drawer: expected pixels are queued by the
// stimulus and popped by a monitor on every plotted cycle.
module tb_vga_box_drawer;

    typedef struct {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } pix_t;

    logic       clk;
    logic       resetn;
    logic [7:0] x_in;
    logic [6:0] y_in;
    logic [2:0] color_in;
    logic       load, draw, clear;
    logic [7:0] VGA_X;
    logic [6:0] VGA_Y;
    logic [2:0] VGA_COLOR;
    logic       plot, busy, done;

    pix_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   busy_cnt = 0;
    int   plot_cnt = 0;
    int   b0, p0;

    vga_box_drawer dut (
        .CLOCK_50 (clk),
        .resetn   (resetn),
        .x_in     (x_in),
        .y_in     (y_in),
        .color_in (color_in),
        .load     (load),
        .draw     (draw),
        .clear    (clear),
        .VGA_X    (VGA_X),
        .VGA_Y    (VGA_Y),
        .VGA_COLOR(VGA_COLOR),
        .plot     (plot),
        .busy     (busy),
        .done     (done)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    always @(negedge clk) begin
        if (resetn) begin
            if (busy) busy_cnt++;
            if (plot) begin
                pix_t e;
                plot_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_plot got=(%0d,%0d,%0d) exp=none",
                             VGA_X, VGA_Y, VGA_COLOR);
                end else begin
                    e = exp_q.pop_front();
                    if (VGA_X !== e.x || VGA_Y !== e.y || VGA_COLOR !== e.c) begin
                        failures++;
                        $display("FAIL pixel got=(%0d,%0d,%0d) exp=(%0d,%0d,%0d)",
                                 VGA_X, VGA_Y, VGA_COLOR, e.x, e.y, e.c);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic push_px(input int x, input int y, input int c);
        pix_t p;
        p.x = 8'(x);
        p.y = 7'(y);
        p.c = 3'(c);
        exp_q.push_back(p);
    endtask

    task automatic push_box(input int x0, input int y0, input int c);
        for (int j = 0; j < 4; j++)
            for (int i = 0; i < 4; i++)
                push_px(x0 + i, y0 + j, c);
    endtask

    task automatic push_clear();
        for (int j = 0; j < 120; j++)
            for (int i = 0; i < 160; i++)
                push_px(i, j, 0);
    endtask

    task automatic finish_op(input string name, input int max_cyc,
                             input int exp_busy, input int busy0);
        int n = 0;
        while (n < max_cyc) begin
            @(negedge clk);
            if (done) break;
            n++;
        end
        chk({name, "_done_seen"}, int'(done), 1);
        @(negedge clk);
        chk({name, "_done_one_cycle"}, int'(done), 0);
        chk({name, "_busy_cycles"}, busy_cnt - busy0, exp_busy);
        chk({name, "_pixels_left"}, exp_q.size(), 0);
    endtask

    initial begin
        resetn = 1'b0; x_in = '0; y_in = '0; color_in = '0;
        load = 1'b0; draw = 1'b0; clear = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_plot", int'(plot), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_vga_x", int'(VGA_X), 0);
        resetn = 1'b1;
        @(negedge clk);

        // basic box: load, then draw on a later edge
        x_in = 8'd10; y_in = 7'd20; color_in = 3'b100; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        push_box(10, 20, 4);
        b0 = busy_cnt;
        draw = 1'b1;
        @(negedge clk);
        draw = 1'b0;
        chk("latency_busy", int'(busy), 1);
        chk("latency_x", int'(VGA_X), 10);
        chk("latency_y", int'(VGA_Y), 20);
        finish_op("box", 40, 16, b0);

        // right/bottom clip, load and draw on the same edge
        x_in = 8'd158; y_in = 7'd118; color_in = 3'b001; load = 1'b1; draw = 1'b1;
        push_px(158, 118, 1); push_px(159, 118, 1);
        push_px(158, 119, 1); push_px(159, 119, 1);
        b0 = busy_cnt; p0 = plot_cnt;
        @(negedge clk);
        load = 1'b0; draw = 1'b0;
        finish_op("clip", 40, 16, b0);
        chk("clip_plots", plot_cnt - p0, 4);

        // far off-screen
        x_in = 8'd255; y_in = 7'd127; color_in = 3'b111; load = 1'b1; draw = 1'b1;
        b0 = busy_cnt; p0 = plot_cnt;
        @(negedge clk);
        load = 1'b0; draw = 1'b0;
        finish_op("far", 40, 16, b0);
        chk("far_plots", plot_cnt - p0, 0);

        // full-screen clear
        push_clear();
        b0 = busy_cnt; p0 = plot_cnt;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        finish_op("clear", 19300, 19200, b0);
        chk("clear_plots", plot_cnt - p0, 19200);

        // clear beats draw; load during clear is ignored
        x_in = 8'd5; y_in = 7'd6; color_in = 3'b010; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        push_clear();
        b0 = busy_cnt;
        draw = 1'b1; clear = 1'b1;
        @(negedge clk);
        draw = 1'b0; clear = 1'b0;
        chk("prio_clear_color", int'(VGA_COLOR), 0);
        repeat (5) @(negedge clk);
        x_in = 8'd50; load = 1'b1;
        repeat (20) @(negedge clk);
        load = 1'b0;
        finish_op("prio", 19300, 19200, b0);
        push_box(5, 6, 2);
        b0 = busy_cnt;
        draw = 1'b1;
        @(negedge clk);
        draw = 1'b0;
        finish_op("old_x", 40, 16, b0);

        // asynchronous reset in the middle of a draw
        x_in = 8'd20; y_in = 7'd30; color_in = 3'b011; load = 1'b1; draw = 1'b1;
        push_box(20, 30, 3);
        @(negedge clk);
        load = 1'b0; draw = 1'b0;
        repeat (3) @(negedge clk);
        #3;
        chk("pre_reset_plot", int'(plot), 1);
        resetn = 1'b0;
        #1;
        chk("async_rst_plot", int'(plot), 0);
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_done", int'(done), 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        p0 = plot_cnt;
        repeat (30) @(negedge clk);
        chk("post_rst_plots", plot_cnt - p0, 0);
        chk("post_rst_busy", int'(busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
